header_encryptor: RTL and testbench
===================================

# header_encryptor

Iterative TEA encryptor: accepts one 64-bit plaintext block and a 128-bit key, and returns the 64-bit ciphertext. It runs one Feistel cycle per enabled clock. It is the transmit-side counterpart of the header decryption and key-search path. It produces the encrypted headers that `full_sync_decryptor` and `key_breaker` consume, and it serves as the reference generator for their benches.

## Interface
- `ROUNDS`, default 32: number of TEA cycles. Legal range is 1..63.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ena` in 1: clock enable. While low, all state is frozen and no handshake completes.
- `in_valid` in 1: `in_block` and `in_key` are valid.
- `in_ready` out 1: block can accept a new request.
- `in_block` in 64: plaintext. v0 = [63:32], v1 = [31:0].
- `in_key` in 128: key. k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0].
- `out_valid` out 1: `out_block` holds the ciphertext.
- `out_ready` in 1: downstream accepts `out_block`.
- `out_block` out 64: ciphertext, same word order as `in_block`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = `ena`.
  - On `in_valid & in_ready`: latch v0, v1, k0..k3; set sum = 0 and round counter = 0; go to RUN.
- RUN: each enabled edge performs one TEA cycle, all arithmetic mod 2^32:
  - sum += 0x9E3779B9
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1 += ((v0'<<4)+k2) ^ (v0'+sum) ^ ((v0'>>5)+k3), where v0' is the updated v0 and sum is the updated sum.
  - Shifts are logical; carries are discarded.
  - Counter increments each cycle. When the counter reaches ROUNDS-1 and that round completes, go to DONE.
- DONE:
  - `out_valid` = 1 and `out_block` = {v0, v1}, both held stable until `out_valid & out_ready & ena`, then go to IDLE.
  - `out_ready` high with `ena` low does not complete a transfer.
- `in_key` and `in_block` are sampled only at the accept edge. Later changes have no effect on a request in flight.
- `in_valid` outside IDLE is ignored. There is no queueing and no back-pressure loss: the request simply waits.

## Timing
- Reset values: `in_ready` = 0 while `rst` is low, then equal to `ena` in IDLE. `out_valid` = 0. `out_block` = 0. Internal v0, v1, sum, counter and keys are all 0.
- Latency: the accept edge is E0. Rounds execute at E1..E_ROUNDS. `out_valid` rises immediately after E_ROUNDS, i.e. 32 enabled cycles after acceptance for the default.
- Throughput: the DONE→IDLE transfer edge does not also accept a new request. `in_ready` rises the cycle after the output transfer.
  - Minimum period is ROUNDS+2 cycles per block (34 for the default).
- `ena` low during RUN stretches latency by exactly the number of disabled cycles. The result is identical.
- Reset asserted mid-RUN or in DONE: all state returns to reset values immediately (asynchronously). The partial result is discarded and no `out_valid` pulse occurs.
- `out_ready` held low in DONE: state is held indefinitely and `in_ready` stays 0.

## Structure
- Package `tea_pkg`, shared with the decryptor:
  - `TEA_DELTA` = 32'h9E3779B9
  - `TEA_ROUNDS_DEFAULT` = 32
  - 2-bit FSM state typedef
  - decryption start sum constant 32'hC6EF3720
- Sub-module `tea_enc_round`: purely combinational.
  - Inputs: v0, v1, sum, k0..k3.
  - Outputs: next v0, v1, sum.
  - The top holds the FSM, counter, registers and handshake.

## Test plan
- Reset, then key = 0 and block = 0, `ena` = 1, `out_ready` = 1:
  - `out_valid` appears exactly 32 cycles after accept.
  - `out_block` = 64'h41EA3A0A_94BAA940.
  - `in_ready` is 0 throughout and returns to 1 one cycle after the transfer.
- Back-pressure: hold `out_ready` = 0 for 10 cycles in DONE.
  - `out_block` stays stable and `in_valid` pulses are ignored.
  - Release `out_ready`: exactly one transfer occurs.
- `ena` toggled 50% randomly during RUN with a random key and block:
  - Result equals the software TEA model.
  - Latency equals 32 plus the number of disabled cycles.
- Change `in_key` and `in_block` every cycle after accept: output matches the values latched at accept.
- Assert `rst` (low) at round 17, release, then issue a new request:
  - No stale `out_valid` appears.
  - The new result is correct.
- Round trip over 100 random {key, block} pairs: `out_block` fed to `full_sync_decryptor` with the same key returns the original block. Also run with `ROUNDS` = 8 against the model.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared TEA definitions for the header encryption / decryption path.
// Holds the key-schedule constant, default round count, FSM state
// encoding and the start sum used by the decryptor for 32 rounds.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA          = 32'h9E3779B9;
  localparam int          TEA_ROUNDS_DEFAULT = 32;
  // DELTA * 32 mod 2^32: where a 32-round decryption starts its sum.
  localparam logic [31:0] TEA_DEC_SUM_START  = 32'hC6EF3720;

  typedef logic [1:0] tea_state_t;

  localparam tea_state_t ST_IDLE = 2'd0;
  localparam tea_state_t ST_RUN  = 2'd1;
  localparam tea_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/tea_enc_round.sv
// One TEA encryption cycle (two Feistel half-rounds), purely combinational.
// Ports:
//   v0, v1         : current half-blocks
//   sum            : running sum before this cycle
//   k0..k3         : key words
//   v0_nxt, v1_nxt : half-blocks after this cycle
//   sum_nxt        : sum after this cycle (sum + DELTA)
module tea_enc_round
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [31:0] v0_nxt,
  output logic [31:0] v1_nxt,
  output logic [31:0] sum_nxt
);

  // The sum is advanced first and both half-rounds use the advanced value;
  // the second half-round mixes in the already-updated v0.
  always_comb begin
    sum_nxt = sum + TEA_DELTA;
    v0_nxt  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_nxt) ^ ((v1 >> 5) + k1));
    v1_nxt  = v1 + (((v0_nxt << 4) + k2) ^ (v0_nxt + sum_nxt) ^ ((v0_nxt >> 5) + k3));
  end

endmodule

// File: rtl/header_encryptor.sv
// Iterative TEA encryptor: one 64-bit block under a 128-bit key, one TEA
// cycle per enabled clock.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   ena           : clock enable; freezes all state and handshakes when low
//   in_valid/in_ready, in_block[63:0], in_key[127:0] : request side
//   out_valid/out_ready, out_block[63:0]             : result side
//   dbg_state[1:0]: current FSM state (IDLE/RUN/DONE)
// Handshakes: a transfer happens on a rising clk edge where valid, ready
// and ena are all high. out_valid/out_block stay stable until transfer.
module header_encryptor
  import tea_pkg::*;
#(
  parameter int ROUNDS = TEA_ROUNDS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic [1:0]   dbg_state
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  tea_state_t  state;
  logic [5:0]  cnt;
  logic [31:0] v0, v1, sum;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] v0_nxt, v1_nxt, sum_nxt;

  tea_enc_round u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .k0      (k0),
    .k1      (k1),
    .k2      (k2),
    .k3      (k3),
    .v0_nxt  (v0_nxt),
    .v1_nxt  (v1_nxt),
    .sum_nxt (sum_nxt)
  );

  // rst is folded in so in_ready reads 0 while reset is held.
  assign in_ready  = rst && ena && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_block = {v0, v1};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      k0    <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            v0    <= in_block[63:32];
            v1    <= in_block[31:0];
            k0    <= in_key[127:96];
            k1    <= in_key[95:64];
            k2    <= in_key[63:32];
            k3    <= in_key[31:0];
            sum   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          v0  <= v0_nxt;
          v1  <= v1_nxt;
          sum <= sum_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ROUND) state <= ST_DONE;
        end
        ST_DONE: begin
          // Returning to IDLE here means this edge never accepts a request.
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_header_encryptor.sv
module tb_header_encryptor;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_block;
  logic [1:0]   dbg_state;

  logic         in_valid8;
  logic         in_ready8;
  logic [63:0]  in_block8;
  logic [127:0] in_key8;
  logic         out_valid8;
  logic [63:0]  out_block8;
  logic [1:0]   dbg_state8;

  int n_checks = 0;
  int n_errors = 0;
  int xfers    = 0;

  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  header_encryptor u_dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .dbg_state (dbg_state)
  );

  header_encryptor #(.ROUNDS(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .ena       (1'b1),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_block  (in_block8),
    .in_key    (in_key8),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .out_block (out_block8),
    .dbg_state (dbg_state8)
  );

  always @(posedge clk) if (out_valid && out_ready && ena) xfers <= xfers + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] tea_enc_model(input logic [127:0] k,
                                                input logic [63:0] b, input int n);
    logic [31:0] y, z, s;
    y = b[63:32]; z = b[31:0]; s = 32'd0;
    for (int i = 0; i < n; i++) begin
      s = s + DELTA;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_dec_model(input logic [127:0] k,
                                                input logic [63:0] b, input int n);
    logic [31:0] y, z, s;
    y = b[63:32]; z = b[31:0]; s = 32'(DELTA * 32'(n));
    for (int i = 0; i < n; i++) begin
      z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      s = s - DELTA;
    end
    return {y, z};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [127:0] k, input logic [63:0] b);
    in_key = k; in_block = b; in_valid = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid, optionally toggling ena
  // and scrambling the request inputs while the block is busy.
  task automatic wait_done(input bit rand_ena, input bit scramble,
                           output int cyc, output int dis, output bit rdy_seen);
    cyc = 0; dis = 0; rdy_seen = 1'b0;
    while (!out_valid && cyc < 400) begin
      if (rand_ena) ena = 1'($urandom_range(0, 1));
      if (scramble) begin
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_block = {$urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      if (!ena) dis++;
      @(posedge clk); #1;
      cyc++;
      if (in_ready) rdy_seen = 1'b1;
    end
    ena = 1'b1; in_valid = 1'b0;
    if (!out_valid) chk("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic transfer();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [127:0] k, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
    int dis; bit rdy;
    accept(k, b);
    wait_done(1'b0, 1'b0, lat, dis, rdy);
    res = out_block;
    transfer();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k;
    logic [63:0]  b, res, held, exp;
    int cyc, dis, lat, x0;
    bit rdy;

    rst = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_block = '0; in_key = '0;
    in_valid8 = 1'b0; in_block8 = '0; in_key8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    ena = 1'b0; #1;
    chk("idle_ready_ena0", 64'(in_ready), 64'd0);
    ena = 1'b1;

    // Zero key / zero block known-answer vector.
    exp_q.push_back(64'h41EA3A0A_94BAA940);
    accept('0, '0);
    wait_done(1'b0, 1'b0, cyc, dis, rdy);
    chk("zero_latency", 64'(cyc), 64'd32);
    chk("zero_ready_busy", 64'(rdy), 64'd0);
    chk("zero_block", out_block, exp_q.pop_front());
    chk("zero_ready_done", 64'(in_ready), 64'd0);
    transfer();
    chk("zero_ready_after", 64'(in_ready), 64'd1);
    chk("zero_valid_after", 64'(out_valid), 64'd0);

    // Back-pressure: hold in DONE, poke in_valid, release for one transfer.
    k = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    b = 64'hDEADBEEF_CAFEF00D;
    exp_q.push_back(tea_enc_model(k, b, 32));
    out_ready = 1'b0;
    accept(k, b);
    wait_done(1'b0, 1'b0, cyc, dis, rdy);
    held = out_block;
    chk("bp_block", held, exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      in_block = 64'(i); in_key = 128'(i);
      @(posedge clk); #1;
      if (out_block !== held || !out_valid || in_ready || dbg_state != 2'd2)
        chk("bp_hold", {out_block[62:0], out_valid}, {held[62:0], 1'b1});
    end
    chk("bp_still_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    x0 = xfers;
    transfer();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_xfer", 64'(xfers - x0), 64'd1);
    chk("bp_idle", 64'(dbg_state), 64'd0);

    // ena toggled during RUN.
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom};
      exp_q.push_back(tea_enc_model(k, b, 32));
      accept(k, b);
      wait_done(1'b1, 1'b0, cyc, dis, rdy);
      chk("ena_latency", 64'(cyc), 64'(32 + dis));
      chk("ena_block", out_block, exp_q.pop_front());
      transfer();
    end

    // out_ready low with ena low must not transfer.
    k = 128'h0; b = 64'h00000001_00000002;
    accept(k, b);
    wait_done(1'b0, 1'b0, cyc, dis, rdy);
    ena = 1'b0;
    @(posedge clk); #1;
    chk("ena0_no_xfer", 64'(out_valid), 64'd1);
    ena = 1'b1;
    chk("ena0_block", out_block, tea_enc_model(k, b, 32));
    transfer();

    // Inputs scrambled after acceptance.
    k = 128'h11111111_22222222_33333333_44444444;
    b = 64'h55555555_66666666;
    exp_q.push_back(tea_enc_model(k, b, 32));
    accept(k, b);
    wait_done(1'b0, 1'b1, cyc, dis, rdy);
    chk("scr_latency", 64'(cyc), 64'd32);
    chk("scr_block", out_block, exp_q.pop_front());
    transfer();
    chk("scr_idle", 64'(dbg_state), 64'd0);

    // Reset asserted at round 17.
    accept(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 64'h12345678_9ABCDEF0);
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_block", out_block, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    k = 128'hCAFEBABE_00C0FFEE_BADC0DE5_FEEDFACE;
    b = 64'h0BADF00D_8BADF00D;
    accept(k, b);
    wait_done(1'b0, 1'b0, cyc, dis, rdy);
    chk("post_rst_latency", 64'(cyc), 64'd32);
    chk("post_rst_block", out_block, tea_enc_model(k, b, 32));
    transfer();

    // Round trip against the decryption model.
    for (int t = 0; t < 100; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom};
      run_txn(k, b, res, lat);
      chk("roundtrip", tea_dec_model(k, res, 32), b);
    end

    // ROUNDS = 8 instance.
    for (int t = 0; t < 2; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom};
      exp = tea_enc_model(k, b, 8);
      in_key8 = k; in_block8 = b; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      cyc = 0;
      while (!out_valid8 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("r8_latency", 64'(cyc), 64'd8);
      chk("r8_block", out_block8, exp);
      @(posedge clk); #1;
      chk("r8_ready", 64'(in_ready8), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
